// File: rtl/uart_mmio_pkg.sv
// Register map, LSR bit positions and byte-lane helpers for the UART window.
package uart_mmio_pkg;

  localparam logic [2:0] UART_THR_OFF = 3'd0;
  localparam logic [2:0] UART_LSR_OFF = 3'd5;
  localparam logic [2:0] UART_SCR_OFF = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] UART_NO_CHAR = 8'hFF;

  typedef struct packed {
    logic       wen;
    logic [2:0] off;
    logic [7:0] wbyte;
    logic       lane_en;
  } req_t;

  function automatic logic [7:0] lane_byte(input logic [63:0] d, input logic [2:0] off);
    return d[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [63:0] place_byte(input logic [7:0] b, input logic [2:0] off);
    return {56'd0, b} << {off, 3'b000};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pop data is combinational from the head, no added latency.
// Push into a full FIFO is taken only when a pop happens on the same edge; otherwise it is dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty/full come only from the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_mmio.sv
// UART window (THR/RBR, LSR, SCR): response one cycle after accept; req_ready drops only for a THR store
// into a full TX FIFO with no pop that cycle. UART_LOOPBACK_EN feeds popped TX bytes into RBR instead of polling.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int TX_GAP   = 1,
  parameter int RX_POLL  = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);
  localparam int GW = $clog2(TX_GAP + 1);

  req_t          req;
  logic          accept;
  logic          thr_hit;
  logic          thr_wr;
  logic          rbr_rd;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic [7:0]    tx_head;
  logic [GW-1:0] gap_cnt;
  logic          dr;
  logic [7:0]    rbr;
  logic [7:0]    scr;
  logic [7:0]    lsr;
  logic [7:0]    rd_byte;
  logic          rx_capture;
  logic [7:0]    rx_byte;

  always_comb begin
    req.wen     = req_wen;
    req.off     = req_addr;
    req.wbyte   = lane_byte(req_wdata, req_addr);
    req.lane_en = req_wmask[req_addr];
  end

  assign thr_hit   = req_valid && req.wen && (req.off == UART_THR_OFF) && req.lane_en;
  // A stalled THR store rides along with a same-cycle pop, so the FIFO never overflows.
  assign req_ready = !(thr_hit && tx_full && !tx_pop);
  assign accept    = req_valid && req_ready;
  assign thr_wr    = accept && thr_hit;
  assign rbr_rd    = accept && !req.wen && (req.off == UART_THR_OFF);

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (thr_wr),
    .push_dat (req.wbyte),
    .pop      (tx_pop),
    .pop_dat  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  assign tx_pop            = !tx_empty && (gap_cnt == '0);
  assign io_uart_out_valid = tx_pop;
  assign io_uart_out_ch    = tx_pop ? tx_head : 8'h00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (tx_pop) begin
      gap_cnt <= GW'(TX_GAP - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign io_uart_in_valid = 1'b0;
  assign rx_capture       = tx_pop && !dr;
  assign rx_byte          = tx_head;
`else
  localparam int PW = $clog2(RX_POLL + 1);
  logic [PW-1:0] poll_cnt;

  // Gated by reset so RX_POLL=1 cannot poll while reset is held.
  assign io_uart_in_valid = !reset && !dr && (poll_cnt == '0);
  assign rx_capture       = io_uart_in_valid && (io_uart_in_ch != UART_NO_CHAR);
  assign rx_byte          = io_uart_in_ch;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_cnt <= PW'(RX_POLL - 1);
    end else if (io_uart_in_valid) begin
      poll_cnt <= PW'(RX_POLL - 1);
    end else if (!dr && (poll_cnt != '0)) begin
      poll_cnt <= poll_cnt - 1'b1;
    end
  end
`endif

  // A capture on the same edge as an RBR read leaves DR set with the new byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dr  <= 1'b0;
      rbr <= 8'h00;
    end else if (rx_capture) begin
      dr  <= 1'b1;
      rbr <= rx_byte;
    end else if (rbr_rd) begin
      dr  <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scr <= 8'h00;
    end else if (accept && req.wen && (req.off == UART_SCR_OFF) && req.lane_en) begin
      scr <= req.wbyte;
    end
  end

  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = dr;
    lsr[LSR_THRE] = !tx_full;
    lsr[LSR_TEMT] = tx_empty;
  end

  always_comb begin
    rd_byte = 8'h00;
    case (req.off)
      UART_THR_OFF: rd_byte = dr ? rbr : 8'h00;
      UART_LSR_OFF: rd_byte = lsr;
      UART_SCR_OFF: rd_byte = scr;
      default:      rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) rsp_rdata <= req.wen ? 64'd0 : place_byte(rd_byte, req.off);
    end
  end

endmodule
